// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the core's execute stage and the data-memory LSU.
// The requester holds the master side; the LSU holds the slave side.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressed RV32I data-memory load/store unit.
// Handles one request at a time and answers after READ_LATENCY cycles.
module dmem_lsu #(
  parameter logic [31:0] BASE_ADDR    = 32'h0020_0000,
  parameter logic [31:0] DEPTH_BYTES  = 32'h0005_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_lsu_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [7:0]    mem [0:DEPTH_BYTES-1];

  logic [1:0]    state;
  logic [2:0]    cnt;
  logic [31:0]   pend_rdata;
  logic [1:0]    pend_err;
  logic [31:0]   rsp_rdata_q;
  logic [1:0]    rsp_err_q;

  logic          accept;
  logic [31:0]   offset;
  logic [31:0]   size;
  logic          is_half;
  logic          is_word;
  logic          legal;
  logic          misaligned;
  logic          out_of_range;
  logic [1:0]    err;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   load_data;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.busy      = (state != S_IDLE);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept = bus.req_valid && bus.req_ready;

  // The range check compares the offset against DEPTH-size so that addresses
  // near 32'hFFFF_FFFF cannot wrap past the end of the region.
  always_comb begin
    offset  = bus.req_addr - BASE_ADDR;
    is_half = (bus.req_funct3[1:0] == 2'b01);
    is_word = (bus.req_funct3 == 3'b010);
    size    = is_word ? 32'd4 : (is_half ? 32'd2 : 32'd1);

    legal = 1'b0;
    case (bus.req_funct3)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = !bus.req_we;
      default:          legal = 1'b0;
    endcase

    misaligned   = (is_half && bus.req_addr[0]) ||
                   (is_word && (bus.req_addr[1:0] != 2'b00));
    out_of_range = (bus.req_addr < BASE_ADDR) || (offset > (DEPTH_BYTES - size));

    if (!legal)
      err = 2'd3;
    else if (misaligned)
      err = 2'd1;
    else if (out_of_range)
      err = 2'd2;
    else
      err = 2'd0;
  end

  always_comb begin
    idx0 = offset[AW-1:0];
    idx1 = idx0 + AW'(1);
    idx2 = idx0 + AW'(2);
    idx3 = idx0 + AW'(3);
    b0   = mem[idx0];
    b1   = mem[idx1];
    b2   = mem[idx2];
    b3   = mem[idx3];

    load_data = 32'h0;
    case (bus.req_funct3)
      3'd0:    load_data = {{24{b0[7]}}, b0};
      3'd1:    load_data = {{16{b1[7]}}, b1, b0};
      3'd2:    load_data = {b3, b2, b1, b0};
      3'd4:    load_data = {24'h0, b0};
      3'd5:    load_data = {16'h0, b1, b0};
      default: load_data = 32'h0;
    endcase
    if (bus.req_we || (err != 2'd0))
      load_data = 32'h0;
  end

  // Stores land on the accept edge; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && (err == 2'd0)) begin
      mem[idx0] <= bus.req_wdata[7:0];
      if (is_half || is_word)
        mem[idx1] <= bus.req_wdata[15:8];
      if (is_word) begin
        mem[idx2] <= bus.req_wdata[23:16];
        mem[idx3] <= bus.req_wdata[31:24];
      end
    end
  end

  // Response data is captured at accept and only exposed on entry to RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      pend_rdata  <= 32'h0;
      pend_err    <= 2'd0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            pend_rdata <= load_data;
            pend_err   <= err;
            if (READ_LATENCY == 1) begin
              state       <= S_RESP;
              rsp_rdata_q <= load_data;
              rsp_err_q   <= err;
            end else begin
              state <= S_WAIT;
              cnt   <= 3'(READ_LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 3'd1) begin
            state       <= S_RESP;
            cnt         <= 3'd0;
            rsp_rdata_q <= pend_rdata;
            rsp_err_q   <= pend_err;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: three instances at latencies 1, 3 and 4,
// each scenario task compares against hand-computed values.
module tb_dmem_lsu;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  dmem_lsu_if b1 ();
  dmem_lsu_if b3 ();
  dmem_lsu_if b4 ();

  dmem_lsu #(.READ_LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  dmem_lsu #(.DEPTH_BYTES(32'h0000_0100), .READ_LATENCY(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  dmem_lsu #(.DEPTH_BYTES(32'h0000_0100), .READ_LATENCY(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        chk;
  } vec_t;

  // One transaction on the latency-1 instance; lat is -1 if no response came.
  task automatic xact1(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic [1:0] err, output int lat);
    rdata = 32'h0;
    err   = 2'd0;
    lat   = -1;
    @(negedge clk);
    b1.req_valid  = 1'b1;
    b1.req_we     = we;
    b1.req_funct3 = f3;
    b1.req_addr   = addr;
    b1.req_wdata  = wdata;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      b1.req_valid = 1'b0;
      if (b1.rsp_valid) begin
        lat   = i;
        rdata = b1.rsp_rdata;
        err   = b1.rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_funct3 = 3'd0; b1.req_addr = 32'h0; b1.req_wdata = 32'h0;
    b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_funct3 = 3'd0; b3.req_addr = 32'h0; b3.req_wdata = 32'h0;
    b4.req_valid = 1'b0; b4.req_we = 1'b0; b4.req_funct3 = 3'd0; b4.req_addr = 32'h0; b4.req_wdata = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (b1.req_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ready: got %b expected 1", b1.req_ready); end
    n_cmp++; if (b1.rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", b1.rsp_valid); end
    n_cmp++; if (b1.rsp_rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", b1.rsp_rdata); end
    n_cmp++; if (b1.rsp_err !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_err: got %0d expected 0", b1.rsp_err); end
    n_cmp++; if (b1.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", b1.busy); end
    n_cmp++; if (b4.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy_lat4: got %b expected 0", b4.busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (b3.req_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL post_reset_ready_lat3: got %b expected 1", b3.req_ready); end
  endtask

  task automatic test_sizing;
    vec_t v[6];
    logic [31:0] rd;
    logic [1:0]  er;
    int          lat;
    v[0] = '{1'b1, 3'd2, 32'h0020_0004, 32'hDEAD_BEEF, 32'h0000_0000, 2'd0, 1'b1};
    v[1] = '{1'b0, 3'd2, 32'h0020_0004, 32'h0,         32'hDEAD_BEEF, 2'd0, 1'b1};
    v[2] = '{1'b0, 3'd0, 32'h0020_0007, 32'h0,         32'hFFFF_FFDE, 2'd0, 1'b1};
    v[3] = '{1'b0, 3'd4, 32'h0020_0007, 32'h0,         32'h0000_00DE, 2'd0, 1'b1};
    v[4] = '{1'b0, 3'd1, 32'h0020_0006, 32'h0,         32'hFFFF_DEAD, 2'd0, 1'b1};
    v[5] = '{1'b0, 3'd5, 32'h0020_0004, 32'h0,         32'h0000_BEEF, 2'd0, 1'b1};
    foreach (v[i]) begin
      xact1(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("[TB] FAIL sizing[%0d]_latency: got %0d expected 1", i, lat); end
      n_cmp++; if (er !== v[i].err) begin n_bad++; $display("[TB] FAIL sizing[%0d]_err: got %0d expected %0d", i, er, v[i].err); end
      if (v[i].chk) begin
        n_cmp++; if (rd !== v[i].rdata) begin n_bad++; $display("[TB] FAIL sizing[%0d]_rdata: got %h expected %h", i, rd, v[i].rdata); end
      end
    end
  endtask

  task automatic test_partial_store;
    vec_t v[3];
    logic [31:0] rd;
    logic [1:0]  er;
    int          lat;
    v[0] = '{1'b1, 3'd0, 32'h0020_0005, 32'h0000_AB12, 32'h0000_0000, 2'd0, 1'b1};
    v[1] = '{1'b1, 3'd1, 32'h0020_0006, 32'h0000_7777, 32'h0000_0000, 2'd0, 1'b1};
    v[2] = '{1'b0, 3'd2, 32'h0020_0004, 32'h0,         32'h7777_12EF, 2'd0, 1'b1};
    foreach (v[i]) begin
      xact1(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat);
      n_cmp++; if (er !== v[i].err) begin n_bad++; $display("[TB] FAIL partial[%0d]_err: got %0d expected %0d", i, er, v[i].err); end
      n_cmp++; if (rd !== v[i].rdata) begin n_bad++; $display("[TB] FAIL partial[%0d]_rdata: got %h expected %h (lat %0d)", i, rd, v[i].rdata, lat); end
    end
  endtask

  task automatic test_errors;
    vec_t v[13];
    logic [31:0] rd;
    logic [1:0]  er;
    int          lat;
    v[0]  = '{1'b1, 3'd2, 32'h0024_FFFC, 32'h0102_0304, 32'h0000_0000, 2'd0, 1'b1};
    v[1]  = '{1'b0, 3'd2, 32'h0020_0002, 32'h0,         32'h0000_0000, 2'd1, 1'b1};
    v[2]  = '{1'b1, 3'd2, 32'h0024_FFFE, 32'h0000_0005, 32'h0000_0000, 2'd1, 1'b1};
    v[3]  = '{1'b1, 3'd2, 32'h0025_0000, 32'hCAFE_F00D, 32'h0000_0000, 2'd2, 1'b1};
    v[4]  = '{1'b0, 3'd2, 32'h0024_FFFC, 32'h0,         32'h0102_0304, 2'd0, 1'b1};
    v[5]  = '{1'b0, 3'd2, 32'h001F_FFFC, 32'h0,         32'h0000_0000, 2'd2, 1'b1};
    v[6]  = '{1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0,         32'h0000_0000, 2'd2, 1'b1};
    v[7]  = '{1'b0, 3'd5, 32'h0024_FFFE, 32'h0,         32'h0000_0102, 2'd0, 1'b1};
    v[8]  = '{1'b0, 3'd2, 32'h0025_0000, 32'h0,         32'h0000_0000, 2'd2, 1'b1};
    v[9]  = '{1'b0, 3'd3, 32'h0020_0001, 32'h0,         32'h0000_0000, 2'd3, 1'b1};
    v[10] = '{1'b1, 3'd4, 32'h0020_0004, 32'h0,         32'h0000_0000, 2'd3, 1'b1};
    v[11] = '{1'b1, 3'd7, 32'h0020_0004, 32'h0,         32'h0000_0000, 2'd3, 1'b1};
    v[12] = '{1'b0, 3'd2, 32'h0020_0004, 32'h0,         32'h7777_12EF, 2'd0, 1'b1};
    foreach (v[i]) begin
      xact1(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat);
      n_cmp++; if (er !== v[i].err) begin n_bad++; $display("[TB] FAIL errors[%0d]_err: got %0d expected %0d (lat %0d)", i, er, v[i].err, lat); end
      if (v[i].chk) begin
        n_cmp++; if (rd !== v[i].rdata) begin n_bad++; $display("[TB] FAIL errors[%0d]_rdata: got %h expected %h", i, rd, v[i].rdata); end
      end
    end
  endtask

  // Cycle-by-cycle view of a latency-3 store followed by a held-valid load.
  task automatic test_latency_back_to_back;
    logic        exp_rv;
    logic [31:0] rd;
    int          lat;
    @(negedge clk);
    b3.req_valid = 1'b1; b3.req_we = 1'b1; b3.req_funct3 = 3'd2;
    b3.req_addr = 32'h0020_0000; b3.req_wdata = 32'hA5A5_5A5A;
    n_cmp++; if (b3.req_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL lat3_c0_ready: got %b expected 1", b3.req_ready); end
    @(negedge clk);
    b3.req_we = 1'b0; b3.req_wdata = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      exp_rv = (k == 3);
      n_cmp++; if (b3.req_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL lat3_c%0d_ready: got %b expected 0", k, b3.req_ready); end
      n_cmp++; if (b3.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL lat3_c%0d_busy: got %b expected 1", k, b3.busy); end
      n_cmp++; if (b3.rsp_valid !== exp_rv) begin n_bad++; $display("[TB] FAIL lat3_c%0d_rsp_valid: got %b expected %b", k, b3.rsp_valid, exp_rv); end
    end
    @(negedge clk);
    n_cmp++; if (b3.req_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL lat3_c4_ready: got %b expected 1", b3.req_ready); end
    n_cmp++; if (b3.rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL lat3_c4_rsp_valid: got %b expected 0", b3.rsp_valid); end
    @(negedge clk);
    b3.req_valid = 1'b0;
    n_cmp++; if (b3.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_accept_c4: busy got %b expected 1", b3.busy); end
    lat = -1;
    rd  = 32'h0;
    for (int i = 6; i <= 12; i++) begin
      @(negedge clk);
      if (b3.rsp_valid) begin lat = i; rd = b3.rsp_rdata; break; end
    end
    n_cmp++; if (lat !== 7) begin n_bad++; $display("[TB] FAIL b2b_rsp_cycle: got %0d expected 7", lat); end
    n_cmp++; if (rd !== 32'hA5A5_5A5A) begin n_bad++; $display("[TB] FAIL b2b_rdata: got %h expected a5a55a5a", rd); end
  endtask

  // Output hold across idle cycles and a store with valid held while busy.
  task automatic test_hold;
    repeat (2) @(negedge clk);
    n_cmp++; if (b3.rsp_rdata !== 32'hA5A5_5A5A) begin n_bad++; $display("[TB] FAIL hold_idle_rdata: got %h expected a5a55a5a", b3.rsp_rdata); end
    b3.req_valid = 1'b1; b3.req_we = 1'b1; b3.req_funct3 = 3'd2;
    b3.req_addr = 32'h0020_0008; b3.req_wdata = 32'h0000_0001;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_cmp++; if (b3.rsp_rdata !== 32'hA5A5_5A5A) begin n_bad++; $display("[TB] FAIL hold_c%0d_rdata: got %h expected a5a55a5a", k, b3.rsp_rdata); end
      n_cmp++; if (b3.rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL hold_c%0d_rsp_valid: got %b expected 0", k, b3.rsp_valid); end
    end
    @(negedge clk);
    b3.req_valid = 1'b0;
    n_cmp++; if (b3.rsp_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL hold_c3_rsp_valid: got %b expected 1", b3.rsp_valid); end
    n_cmp++; if (b3.rsp_rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL hold_c3_rdata: got %h expected 00000000", b3.rsp_rdata); end
    @(negedge clk);
    n_cmp++; if (b3.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL hold_c4_busy: got %b expected 0", b3.busy); end
  endtask

  task automatic test_reset_midop;
    logic        saw;
    logic [31:0] rd;
    logic [1:0]  er;
    int          lat;
    @(negedge clk);
    b4.req_valid = 1'b1; b4.req_we = 1'b1; b4.req_funct3 = 3'd2;
    b4.req_addr = 32'h0020_0010; b4.req_wdata = 32'h1122_3344;
    @(negedge clk);
    b4.req_valid = 1'b0;
    n_cmp++; if (b4.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL midop_c1_busy: got %b expected 1", b4.busy); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (b4.req_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL midop_ready: got %b expected 1", b4.req_ready); end
    n_cmp++; if (b4.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL midop_busy: got %b expected 0", b4.busy); end
    n_cmp++; if (b4.rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midop_rsp_valid: got %b expected 0", b4.rsp_valid); end
    n_cmp++; if (b4.rsp_err !== 2'd0) begin n_bad++; $display("[TB] FAIL midop_err: got %0d expected 0", b4.rsp_err); end
    n_cmp++; if (b1.rsp_rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL midop_lat1_rdata_cleared: got %h expected 00000000", b1.rsp_rdata); end
    saw = 1'b0;
    repeat (2) begin @(negedge clk); if (b4.rsp_valid) saw = 1'b1; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (b4.rsp_valid) saw = 1'b1; end
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("[TB] FAIL midop_dropped_rsp: got %b expected 0", saw); end
    b4.req_valid = 1'b1; b4.req_we = 1'b0; b4.req_funct3 = 3'd2;
    b4.req_addr = 32'h0020_0010; b4.req_wdata = 32'h0;
    lat = -1; rd = 32'h0; er = 2'd0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      b4.req_valid = 1'b0;
      if (b4.rsp_valid) begin lat = i; rd = b4.rsp_rdata; er = b4.rsp_err; break; end
    end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("[TB] FAIL midop_reload_latency: got %0d expected 4", lat); end
    n_cmp++; if (rd !== 32'h1122_3344) begin n_bad++; $display("[TB] FAIL midop_reload_rdata: got %h expected 11223344", rd); end
    n_cmp++; if (er !== 2'd0) begin n_bad++; $display("[TB] FAIL midop_reload_err: got %0d expected 0", er); end
  endtask

  initial begin
    test_reset();
    test_sizing();
    test_partial_store();
    test_errors();
    test_latency_back_to_back();
    test_hold();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Parametrised data-memory load/store unit that replaces the ad-hoc word-only data memory inside the RV32I core. It takes one load or store request at a time over a valid/ready handshake. It applies RV32I funct3 sizing and extension (LB/LH/LW/LBU/LHU/SB/SH/SW), checks alignment and address range, and returns a response after a configurable latency. It sits between the core's execute stage and the byte-addressed DMEM region.

Parameters:
BASE_ADDR, 32'h0020_0000, first byte address of the DMEM region
DEPTH_BYTES, 32'h0005_0000, region size in bytes; must be a multiple of 4 and at least 4
READ_LATENCY, 1, cycles from the accept cycle to the response cycle; legal range 1..4

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 of the load/store instruction
req_addr  in  32  byte address
req_wdata  in  32  store data; low bytes are used for SB/SH
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  2  0 ok, 1 misaligned, 2 out-of-range, 3 illegal funct3
busy  out  1  a transaction is in flight (not IDLE)

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock clk.
  - Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, state=IDLE, latency counter=0.
  - Memory array is not reset; its contents are undefined until written.
- Storage: byte array of DEPTH_BYTES, little-endian. Index = req_addr - BASE_ADDR (32-bit subtraction).
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Accept when req_valid && req_ready.
  - On accept: if READ_LATENCY==1, go to RESP; otherwise go to WAIT with counter = READ_LATENCY-1.
  - WAIT: req_ready=0. Counter decrements each cycle; go to RESP when the counter reaches 1.
  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then IDLE.
- Timing:
  - Accept cycle = cycle 0; rsp_valid is high in cycle READ_LATENCY only.
  - Maximum throughput is one request per READ_LATENCY+1 cycles.
  - Only one transaction is outstanding; there is no response backpressure.
- Access size:
  - Byte: funct3 0 and 4.
  - Half: funct3 1 and 5.
  - Word: funct3 2.
- Legal funct3:
  - Loads: 0, 1, 2, 4, 5.
  - Stores: 0, 1, 2.
  - Any other value is illegal.
- Error checks, all evaluated on the accept edge, in priority order:
  - Illegal funct3 (3) > misaligned (1) > out-of-range (2).
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Out-of-range: addr < BASE_ADDR, or (addr - BASE_ADDR) > DEPTH_BYTES - size. This form must not overflow near 32'hFFFF_FFFF.
- Stores:
  - Committed on the accept edge, only when there is no error.
  - SB writes wdata[7:0]; SH writes wdata[15:0]; SW writes all 4 bytes.
  - Other bytes are untouched; rsp_rdata=0.
  - On error, memory is unchanged.
- Loads:
  - Data is read on the accept edge and registered through the latency pipeline.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW returns the word unchanged.
  - On error, rsp_rdata=0.
- Output hold: rsp_rdata and rsp_err are updated in the RESP cycle and held until the next RESP or reset.
- Requests outside IDLE are ignored (req_ready=0). The requester must hold req_valid and its fields stable until accepted.
- Reset mid-transaction:
  - The pending response is dropped; no rsp_valid is issued.
  - A store already committed on its accept edge stays in memory.
  - The unit returns to IDLE.
- A request is accepted in the first IDLE cycle after RESP; there is no bubble beyond RESP.

Test Plan:
- Sizing and extension (LAT=1): SW 0xDEADBEEF @0x00200004, then:
  - LW @0x00200004 -> 0xDEADBEEF, err 0
  - LB @0x00200007 -> 0xFFFFFFDE
  - LBU @0x00200007 -> 0x000000DE
  - LH @0x00200006 -> 0xFFFFDEAD
  - LHU @0x00200004 -> 0x0000BEEF
- Partial stores: after the test above, SB 0xAB12 @0x00200005 and SH 0x7777 @0x00200006, then LW @0x00200004 -> 0x777712EF.
- Errors:
  - LW @0x00200002 -> err 1, rdata 0.
  - SW 0x5 @0x0024FFFE -> err 1 (misaligned beats out-of-range).
  - SW @0x00250000 -> err 2, memory unchanged.
  - LW @0x001FFFFC -> err 2.
  - LW @0x0024FFFC -> err 0.
  - LB @0xFFFFFFFF -> err 2.
  - Load funct3=3 -> err 3.
  - Store funct3=4 -> err 3.
- Latency (LAT=3):
  - Accept in cycle 0 -> req_ready=0 and busy=1 in cycles 1-3; rsp_valid only in cycle 3.
  - A back-to-back request held valid is accepted in cycle 4.
- Reset mid-op (LAT=4): SW 0x11223344 @0x00200010 accepted, then rst_n low in cycle 2.
  - Required: no rsp_valid; all outputs return to reset values.
  - After release, LW @0x00200010 -> 0x11223344.
- Handshake: req_valid held while busy -> no second accept; rsp_rdata holds its last value until the next rsp_valid.
